// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// holds each instruction for decode; resolves jr/jump/branch redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE} state_t;

  state_t      state, state_nxt;
  logic        capture, advance;
  logic [31:0] next_pc;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      S_FETCH: begin
        capture   = imem_ack;
        state_nxt = imem_ack ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        capture = imem_ack;
        if (imem_ack) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        advance = !stall;
        if (!stall) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Redirect priority: jr > jump > branch > sequential
  always_comb begin
    next_pc = pc_plus4;
    if (jr)                next_pc = {jr_target[31:2], 2'b00};
    else if (jump)         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken) next_pc = pc_plus4 + (branch_offset << 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (capture) instr <= imem_rdata;
      if (advance) pc    <= next_pc;
    end
  end

  // Request is gated by rst so an abandoned request drops immediately
  assign imem_req    = !rst && (state != S_ISSUE);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign pc_plus4    = pc + 32'd4;
  assign imm16       = instr[15:0];
  assign misalign    = advance && jr && (jr_target[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a chained table of single-instruction
// fetch/issue vectors, then hand sequences for wait states, stall and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jr(jr), .jr_target(jr_target),
    .instr(instr), .imm16(imm16), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;       // expected fetch address
    logic [31:0] word;     // instruction returned by memory
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic        jrr;
    logic [31:0] jtgt;
    logic [31:0] nxt;      // expected next fetch address
    logic        mis;      // expected misalign pulse
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //           pc            word          br off           jmp jr  jtgt          nxt           mis
    vecs[0]  = '{32'h0000_3000, 32'h2008_0005, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 0};
    vecs[1]  = '{32'h0000_3004, 32'h0000_0000, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 0};
    vecs[2]  = '{32'h0000_3008, 32'h1111_2222, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 0};
    vecs[3]  = '{32'h0000_300C, 32'h3333_4444, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3010, 0};
    vecs[4]  = '{32'h0000_3010, 32'h1000_FFFE, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,         32'h0000_300C, 0};
    vecs[5]  = '{32'h0000_300C, 32'h0000_0008, 0, 32'h0,         0, 1, 32'h0000_3000, 32'h0000_3000, 0};
    vecs[6]  = '{32'h0000_3000, 32'h0800_0C40, 0, 32'h0,         1, 0, 32'h0,         32'h0000_3100, 0};
    vecs[7]  = '{32'h0000_3100, 32'h0000_0008, 1, 32'h0000_0010, 1, 1, 32'h0000_4006, 32'h0000_4004, 1};
    vecs[8]  = '{32'h0000_4004, 32'h0BFF_FFFF, 0, 32'h0,         1, 0, 32'h0,         32'h0FFF_FFFC, 0};
    vecs[9]  = '{32'h0FFF_FFFC, 32'hABCD_1234, 0, 32'h0,         0, 0, 32'h0,         32'h1000_0000, 0};
    vecs[10] = '{32'h1000_0000, 32'h0000_0008, 0, 32'h0,         0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1};
    vecs[11] = '{32'hFFFF_FFFC, 32'h5555_AAAA, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 0};
    vecs[12] = '{32'h0000_0000, 32'h1000_0C00, 1, 32'h0000_0C00, 0, 0, 32'h0,         32'h0000_3004, 0};
    vecs[13] = '{32'h0000_3004, 32'h0000_0008, 0, 32'h0,         0, 1, 32'hF000_0000, 32'hF000_0000, 0};
    vecs[14] = '{32'hF000_0000, 32'h0800_0010, 0, 32'h0,         1, 0, 32'h0,         32'hF000_0040, 0};
    vecs[15] = '{32'hF000_0040, 32'h1000_0008, 1, 32'h0000_0008, 0, 0, 32'h0,         32'hF000_0064, 0};
    vecs[16] = '{32'hF000_0064, 32'h0000_0008, 0, 32'h0,         0, 1, 32'h0000_3000, 32'h0000_3000, 0};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jr = 1'b0; jr_target = '0;

    #2;
    check("rst_req",   {31'b0, imem_req},    32'd0);
    check("rst_pc",    pc,                   32'h0000_3000);
    check("rst_instr", instr,                32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_mis",   {31'b0, misalign},    32'd0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      imem_ack = 1'b1; imem_rdata = vecs[i].word;
      #1;
      check($sformatf("v%0d_req", i),   {31'b0, imem_req}, 32'd1);
      check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].pc);
      check($sformatf("v%0d_valid0", i), {31'b0, instr_valid}, 32'd0);
      cyc();
      imem_ack = 1'b0;
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'd1);
      check($sformatf("v%0d_instr", i), instr, vecs[i].word);
      check($sformatf("v%0d_imm16", i), {16'b0, imm16}, {16'b0, vecs[i].word[15:0]});
      check($sformatf("v%0d_pc", i),    pc, vecs[i].pc);
      check($sformatf("v%0d_pc4", i),   pc_plus4, vecs[i].pc + 32'd4);
      check($sformatf("v%0d_req_iss", i), {31'b0, imem_req}, 32'd0);
      branch_taken = vecs[i].br; branch_offset = vecs[i].off;
      jump = vecs[i].jmp; jr = vecs[i].jrr; jr_target = vecs[i].jtgt;
      #1;
      check($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].mis});
      cyc();
      branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
      #1;
      check($sformatf("v%0d_mis_off", i), {31'b0, misalign}, 32'd0);
      check($sformatf("v%0d_next", i), imem_addr, vecs[i].nxt);
    end

    // Three wait cycles: request held four cycles at a constant address
    for (int k = 0; k < 4; k++) begin
      imem_ack = (k == 3); imem_rdata = (k == 3) ? 32'h1234_5678 : 32'hFFFF_0000;
      #1;
      check($sformatf("wait%0d_req", k),   {31'b0, imem_req}, 32'd1);
      check($sformatf("wait%0d_addr", k),  imem_addr, 32'h0000_3000);
      check($sformatf("wait%0d_valid", k), {31'b0, instr_valid}, 32'd0);
      cyc();
    end
    imem_ack = 1'b0;
    check("wait_valid", {31'b0, instr_valid}, 32'd1);
    check("wait_instr", instr, 32'h1234_5678);

    // Stall in ISSUE: redirects and stray acks ignored
    stall = 1'b1; branch_offset = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      branch_taken = k[0]; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      check($sformatf("stall%0d_req", k),   {31'b0, imem_req}, 32'd0);
      check($sformatf("stall%0d_valid", k), {31'b0, instr_valid}, 32'd1);
      check($sformatf("stall%0d_pc", k),    pc, 32'h0000_3000);
      check($sformatf("stall%0d_instr", k), instr, 32'h1234_5678);
      cyc();
    end
    check("stall_end_pc",    pc, 32'h0000_3000);
    check("stall_end_instr", instr, 32'h1234_5678);
    stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    cyc();
    check("post_stall_addr", imem_addr, 32'h0000_3004);
    check("post_stall_req",  {31'b0, imem_req}, 32'd1);
    cyc();
    check("in_wait_req",   {31'b0, imem_req}, 32'd1);
    check("in_wait_valid", {31'b0, instr_valid}, 32'd0);

    // Reset mid-WAIT takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    check("rstw_req",   {31'b0, imem_req}, 32'd0);
    check("rstw_pc",    pc, 32'h0000_3000);
    check("rstw_valid", {31'b0, instr_valid}, 32'd0);
    check("rstw_instr", instr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_req",  {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
